// File: rtl/alu_logic_pkg.sv
// alu_logic_pkg: shared types and default widths for the ALU_Logical controller.
//   op_e    : request opcode (AND, OR, NEG, NOT)
//   state_e : controller FSM state
package alu_logic_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_NEG, OP_NOT} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
endpackage

// File: rtl/alu_logic_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a registered last-granted pointer.
//   clk, clr_n : clock, async active-low reset (last resets to 1)
//   req_i      : request vector
//   en_i       : a grant is consumed this cycle; updates the pointer
//   gnt_o      : one-hot (or zero) grant
module rr_arb2 (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    logic last_q, last_d;
    always_comb begin
        // On a tie the requester not granted last wins; a lone request always wins.
        gnt_o  = (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
        last_d = en_i ? gnt_o[1] : last_q;
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/alu_logic_ctrl.sv
// alu_logic_ctrl: arbitrating controller for the external ALU_Logical block.
//   clk, clr_n              : clock, async active-low reset
//   req_valid/req_ready     : per-requester handshake (bit i = requester i)
//   req_op*/req_a*/req_b*   : opcode and operands per requester
//   alu_a/alu_b, alu_<sel>  : registered operands and one-hot selects to the ALU
//   alu_c                   : combinational ALU result
//   rsp_valid/rsp_ready     : response handshake; rsp_id/rsp_data tag and result
//   op_count                : saturating completed-operation counter
//   chk_err                 : sticky self-check error (ALU_LOGIC_CHECK_EN), else 0
// Optional feature macro: ALU_LOGIC_CHECK_EN
module alu_logic_ctrl
    import alu_logic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_and,
    output logic              alu_or,
    output logic              alu_neg,
    output logic              alu_not,
    input  logic [DATA_W-1:0] alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  op_count,
    output logic              chk_err
);
    state_e            state_q, state_d;
    logic [1:0]        gnt;
    logic              accept;
    op_e               op;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [3:0]        sel_q, sel_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .clr_n (clr_n),
        .req_i (req_valid),
        .en_i  (accept),
        .gnt_o (gnt)
    );

    assign accept    = (state_q == S_IDLE) && (|req_valid);
    assign req_ready = (state_q == S_IDLE) ? gnt : 2'b00;
    assign op        = op_e'(gnt[1] ? req_op1 : req_op0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        id_d    = id_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_ISSUE;
                id_d    = gnt[1];
                a_d     = gnt[1] ? req_a1 : req_a0;
                b_d     = gnt[1] ? req_b1 : req_b0;
                // Select bits are ordered {and, or, neg, not}, matching the opcode order.
                sel_d   = 4'b1000 >> op;
            end
            S_ISSUE: begin
                state_d = S_RESP;
                data_d  = alu_c;
            end
            S_RESP: if (rsp_ready) begin
                state_d = S_IDLE;
                sel_d   = '0;
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign {alu_and, alu_or, alu_neg, alu_not} = sel_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign op_count  = cnt_q;

`ifdef ALU_LOGIC_CHECK_EN
    logic [DATA_W-1:0] exp_c;
    logic              err_q;
    // The registered one-hot select is the registered opcode.
    assign exp_c = sel_q[3] ? (a_q & b_q) :
                   sel_q[2] ? (a_q | b_q) :
                   sel_q[1] ? (~a_q + 1'b1) : ~a_q;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) err_q <= 1'b0;
        else        err_q <= err_q | ((state_q == S_ISSUE) && (alu_c != exp_c));
    end
    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_logic_ctrl.sv
// tb_alu_logic_ctrl: directed self-checking bench for alu_logic_ctrl with a behavioural ALU.
module tb_alu_logic_ctrl;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr_n = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [1:0]    req_op0 = 2'd0, req_op1 = 2'd0;
    logic [DW-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [DW-1:0] alu_a, alu_b, alu_c, rsp_data, good_c;
    logic          alu_and, alu_or, alu_neg, alu_not;
    logic          rsp_valid, rsp_id, chk_err;
    logic          rsp_ready = 1'b0;
    logic [CW-1:0] op_count;
    logic [3:0]    sel;
    logic          bad = 1'b0;
    int            n_cmp = 0, n_err = 0;
    int            cnt_m = 0;
    logic          last_m = 1'b1;

    always #5 clk = ~clk;

    alu_logic_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_and(alu_and), .alu_or(alu_or), .alu_neg(alu_neg), .alu_not(alu_not),
        .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .op_count(op_count), .chk_err(chk_err)
    );

    assign sel = {alu_and, alu_or, alu_neg, alu_not};

    always_comb begin
        good_c = '0;
        if (alu_and)      good_c = alu_a & alu_b;
        else if (alu_or)  good_c = alu_a | alu_b;
        else if (alu_neg) good_c = -alu_a;
        else if (alu_not) good_c = ~alu_a;
    end
    assign alu_c = bad ? (good_c ^ 32'hDEADBEEF) : good_c;

    task automatic test_reset;
        #2 clr_n = 1'b0;
        #1;
        n_cmp++; if ({req_ready, rsp_valid, sel, rsp_id, chk_err, op_count} !== '0) begin n_err++; $display("FAIL reset_ctl got %h exp 0", {req_ready, rsp_valid, sel, rsp_id, chk_err, op_count}); end
        n_cmp++; if ({alu_a, alu_b, rsp_data} !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", {alu_a, alu_b, rsp_data}); end
        @(negedge clk) clr_n = 1'b1;
        cnt_m = 0; last_m = 1'b1;
    endtask

    task automatic test_and;
        req_valid = 2'b01; req_op0 = 2'd0; req_a0 = 32'hF0F0F0F0; req_b0 = 32'hFF00FF00; rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL and_grant got %b exp 01", req_ready); end
        @(posedge clk) #1 req_valid = 2'b00; last_m = 1'b0;
        @(negedge clk);
        n_cmp++; if (sel !== 4'b1000) begin n_err++; $display("FAIL and_sel_issue got %b exp 1000", sel); end
        n_cmp++; if ({alu_a, alu_b} !== {32'hF0F0F0F0, 32'hFF00FF00}) begin n_err++; $display("FAIL and_operands got %h exp f0f0f0f0ff00ff00", {alu_a, alu_b}); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL and_early_rsp got %b exp 0", rsp_valid); end
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'hF000F000}) begin n_err++; $display("FAIL and_rsp got %b/%b/%h exp 1/0/f000f000", rsp_valid, rsp_id, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
        n_cmp++; if ({rsp_valid, sel} !== 5'b0) begin n_err++; $display("FAIL and_idle got %b/%b exp 0/0000", rsp_valid, sel); end
        n_cmp++; if (op_count !== 4'(cnt_m)) begin n_err++; $display("FAIL and_count got %0d exp %0d", op_count, cnt_m); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        req_valid = 2'b01; req_op0 = 2'd2; req_a0 = 32'h1; req_b0 = 32'h1234; rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_grant got %b exp 01", req_ready); end
        last_m = 1'b0;
        @(negedge clk);
        n_cmp++; if ({sel, alu_b} !== {4'b0010, 32'h1234}) begin n_err++; $display("FAIL bp_issue got %b/%h exp 0010/00001234", sel, alu_b); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if ({rsp_valid, rsp_id, req_ready, rsp_data} !== {1'b1, 1'b0, 2'b00, 32'hFFFFFFFF}) begin n_err++; $display("FAIL bp_hold%0d got %b/%b/%b/%h exp 1/0/00/ffffffff", k, rsp_valid, rsp_id, req_ready, rsp_data); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_next_ready got %b exp 01", req_ready); end
        @(negedge clk);
        n_cmp++; if (sel !== 4'b0010) begin n_err++; $display("FAIL bp_next_accept got %b exp 0010", sel); end
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (rsp_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bp_second got %h exp ffffffff", rsp_data); end
        @(negedge clk);
        cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
        n_cmp++; if (op_count !== 4'(cnt_m)) begin n_err++; $display("FAIL bp_count got %0d exp %0d", op_count, cnt_m); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        req_valid = 2'b10; req_op1 = 2'd0; req_a1 = 32'h0F0F; req_b1 = 32'h00FF; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        n_cmp++; if (sel !== 4'b1000) begin n_err++; $display("FAIL rm_issue got %b exp 1000", sel); end
        #1 clr_n = 1'b0;
        #1;
        n_cmp++; if ({req_ready, rsp_valid, sel, rsp_id, chk_err, op_count} !== '0) begin n_err++; $display("FAIL rm_ctl got %h exp 0", {req_ready, rsp_valid, sel, rsp_id, chk_err, op_count}); end
        n_cmp++; if ({alu_a, alu_b, rsp_data} !== '0) begin n_err++; $display("FAIL rm_data got %h exp 0", {alu_a, alu_b, rsp_data}); end
        cnt_m = 0; last_m = 1'b1;
        @(negedge clk) clr_n = 1'b1; req_valid = 2'b10; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rm_lone1 got %b exp 10", req_ready); end
        last_m = 1'b1;
        @(negedge clk) req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'h000F}) begin n_err++; $display("FAIL rm_rsp got %b/%b/%h exp 1/1/0000000f", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
        req_valid = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rm_tie got %b exp 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_back_to_back;
        logic w;
        req_valid = 2'b11; rsp_ready = 1'b1;
        req_op0 = 2'd1; req_a0 = 32'h5; req_b0 = 32'h30;
        req_op1 = 2'd3; req_a1 = 32'h5; req_b1 = 32'hABCD;
        for (int k = 0; k < 4; k++) begin
            w = ~last_m;
            #1;
            n_cmp++; if (req_ready !== (w ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL b2b_grant%0d got %b exp %b", k, req_ready, w ? 2'b10 : 2'b01); end
            last_m = w;
            @(negedge clk);
            n_cmp++; if ({req_ready, sel} !== {2'b00, (w ? 4'b0001 : 4'b0100)}) begin n_err++; $display("FAIL b2b_sel%0d got %b/%b", k, req_ready, sel); end
            @(negedge clk);
            n_cmp++; if ({rsp_id, rsp_data} !== {w, (w ? 32'hFFFFFFFA : 32'h35)}) begin n_err++; $display("FAIL b2b_rsp%0d got %b/%h exp %b/%h", k, rsp_id, rsp_data, w, w ? 32'hFFFFFFFA : 32'h35); end
            @(negedge clk);
            cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
        end
        req_valid = 2'b00;
        n_cmp++; if (op_count !== 4'(cnt_m)) begin n_err++; $display("FAIL b2b_count got %0d exp %0d", op_count, cnt_m); end
    endtask

    task automatic test_saturate;
        rsp_ready = 1'b1; req_op0 = 2'd0; req_a0 = '1; req_b0 = 32'h5A5A5A5A;
        for (int k = 0; k < 16; k++) begin
            req_valid = 2'b01;
            @(negedge clk) req_valid = 2'b00;
            @(negedge clk);
            @(negedge clk);
            cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
            n_cmp++; if (op_count !== 4'(cnt_m)) begin n_err++; $display("FAIL sat_count%0d got %0d exp %0d", k, op_count, cnt_m); end
        end
        last_m = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_chk;
        req_valid = 2'b01; req_op0 = 2'd1; req_a0 = 32'h12; req_b0 = 32'h21; rsp_ready = 1'b0; bad = 1'b1;
        @(negedge clk) req_valid = 2'b00;
        n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_issue got %b exp 0", chk_err); end
        @(negedge clk) bad = 1'b0;
        n_cmp++; if (rsp_data !== (32'h33 ^ 32'hDEADBEEF)) begin n_err++; $display("FAIL chk_data got %h exp %h", rsp_data, 32'h33 ^ 32'hDEADBEEF); end
`ifdef ALU_LOGIC_CHECK_EN
        n_cmp++; if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_rise got %b exp 1", chk_err); end
`else
        n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_off got %b exp 0", chk_err); end
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
`ifdef ALU_LOGIC_CHECK_EN
        n_cmp++; if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_sticky got %b exp 1", chk_err); end
`else
        n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_off_idle got %b exp 0", chk_err); end
`endif
        clr_n = 1'b0;
        #1;
        n_cmp++; if ({chk_err, op_count} !== '0) begin n_err++; $display("FAIL chk_clear got %b/%0d exp 0/0", chk_err, op_count); end
        @(negedge clk) clr_n = 1'b1; rsp_ready = 1'b0;
        cnt_m = 0; last_m = 1'b1;
    endtask

    initial begin
        test_reset;
        test_and;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_saturate;
        test_chk;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_logic_ctrl.md
# alu_logic_ctrl

Controller and two-port arbiter for the shared `ALU_Logical` datapath block (AND/OR/NEG/NOT). It accepts operation requests from two requesters over valid/ready handshakes, grants one at a time round-robin, and drives the ALU's operand and one-hot select lines. It captures the combinational ALU result into a register and returns it on a tagged response channel. It sits between the MiniSRC control unit (requester 0), the debug/self-test port (requester 1) and the ALU.

## Interface
- `DATA_W`, default 32: operand and result width.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `clr_n`  in  1: reset, asynchronous assert, active-low.
- `req_valid`  in  2: per-requester request valid; bit i is requester i.
- `req_ready`  out  2: per-requester accept.
- `req_op0`, `req_op1`  in  2 each: opcode. 0=AND, 1=OR, 2=NEG, 3=NOT.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DATA_W each: operands.
- `alu_a`, `alu_b`  out  DATA_W: registered operands to the ALU.
- `alu_and`, `alu_or`, `alu_neg`, `alu_not`  out  1 each: registered one-hot selects.
- `alu_c`  in  DATA_W: ALU result, combinational from `alu_a`/`alu_b`/selects.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_id`  out  1: requester that owns the result.
- `rsp_data`  out  DATA_W: registered result.
- `op_count`  out  CNT_W: completed operations, saturating.
- `chk_err`  out  1: sticky self-check error (see Configuration).

## Operation
- FSM states:
  - IDLE: `req_ready` is nonzero only here.
  - ISSUE: on the accept edge, operands and opcode are registered and the matching select is raised.
  - RESP: result held.
- Transitions:
  - IDLE→ISSUE on any `req_valid`.
  - ISSUE→RESP unconditionally; `alu_c` is captured into `rsp_data` on the ISSUE→RESP edge.
  - RESP→IDLE on `rsp_ready`.
- Arbitration:
  - `req_ready[i]` = IDLE & grant[i], and is only ever one-hot.
  - When both requesters are valid, the one not granted last wins.
  - A `last` pointer updates on each accept; its reset value is 1, so requester 0 wins the first tie.
  - A lone valid requester always wins.
- Selects:
  - Exactly one select is high in ISSUE and RESP.
  - All selects are 0 in IDLE and after reset.
  - `alu_a`/`alu_b` hold their values through RESP.
  - NEG and NOT use `alu_a` only; `alu_b` is still loaded from the request.
- `op_count` increments on each RESP→IDLE transition and saturates at all ones; it does not wrap.
- A request withdrawn before acceptance is not tracked.
- Reset mid-operation:
  - The FSM goes to IDLE; the captured result is discarded.
  - `rsp_valid`, selects, `req_ready` and `op_count` are forced to 0 and `last` to 1.
  - `chk_err` is cleared.

## Timing
- Reset values: every output is 0, including `alu_a`, `alu_b`, `rsp_data`, `rsp_id` and `op_count`.
- With the accept edge at cycle T:
  - Selects and operands are valid during cycle T+1.
  - `rsp_valid` rises at T+2.
  - Latency is 2 cycles from accept to response.
- Minimum 3 cycles per operation: accept, issue, and one RESP cycle with `rsp_ready`=1.
- Response back-pressure: `rsp_valid` is held and `rsp_data`/`rsp_id` stay stable until `rsp_ready`.
- A new accept is possible in the cycle after the response handshake.

## Configuration
- `ALU_LOGIC_CHECK_EN` defined:
  - In ISSUE the controller computes its own expected result from the registered operands and opcode: a&b, a|b, ~a+1, ~a.
  - It compares the expected result with `alu_c`; a mismatch sets `chk_err`.
  - `chk_err` stays set until reset.
- Undefined: `chk_err` is tied 0 and the comparator logic is absent.

## Structure
- Package `alu_logic_pkg`:
  - Opcode enum (`OP_AND`, `OP_OR`, `OP_NEG`, `OP_NOT`).
  - FSM state enum.
  - Default `DATA_W`/`CNT_W` constants.
- One sub-module, `rr_arb2`: 2-way round-robin grant with a registered last pointer.
- The ALU itself stays external.

## Test plan
- Reset, then requester 0 issues AND with a=0xF0F0F0F0, b=0xFF00FF00:
  - AND select is high only at T+1.
  - `rsp_valid` rises at T+2 with `rsp_data`=0xF000F000 and `rsp_id`=0.
  - `op_count`=1 after the handshake.
- Both requesters valid continuously, requester 0 OR and requester 1 NOT with a=0x00000005:
  - Grants alternate 0,1,0,1.
  - Results are 0x5|b and 0xFFFFFFFA.
- NEG with a=0x00000001 and `rsp_ready` held low for 5 cycles:
  - `rsp_data`=0xFFFFFFFF holds stable.
  - `req_ready`=0 throughout.
  - The next accept follows the handshake by exactly one cycle.
- Assert `clr_n` low during ISSUE:
  - All outputs go to 0 immediately.
  - After release, requester 1 alone is granted and requester 0 wins the following tie.
- Preload `op_count` near saturation (CNT_W=4, 16 operations): the counter stays at 0xF.
- With `ALU_LOGIC_CHECK_EN` defined, force `alu_c` to a wrong value for one operation:
  - `chk_err` rises at the RESP edge and stays high until reset.
  - Without the macro, `chk_err` stays 0.
